// File: rtl/mem_pkg.sv
// Shared definitions for the RAM arbiter slice.
// Command encodings, arbiter states and a command-valid helper.
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  function automatic logic cmd_valid(
    input logic [1:0] c
  );
    return (c == MREAD) || (c == MWRITE);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the two RAM ports.
// winner=0 picks port 0, winner=1 picks port 1.
module arb_pick
  import mem_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic guard_hit,
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    unique case (1'b1)
      (req1 && !req0): winner = 1'b1;
      (req0 && req1):  winner = FIXED_PRI ? guard_hit : !last;
      default:         winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 512x16 synchronous RAM.
// Grants one port, issues the RAM command and returns read data.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int FIXED_PRI  = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  p0_cmd,
  input  logic [8:0]  p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [15:0] p0_rdata,
  input  logic [1:0]  p1_cmd,
  input  logic [8:0]  p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] p1_rdata,
  output logic [1:0]  ram_cmd,
  output logic [8:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        busy
);

  arb_state_t  state, state_d;
  logic [1:0]  cnt, cnt_d;
  logic [3:0]  consec;
  logic        last, owner;
  logic        req0, req1;
  logic        win, guard_hit;
  logic        grant, cap;

  assign req0      = cmd_valid(p0_cmd);
  assign req1      = cmd_valid(p1_cmd);
  assign guard_hit = (consec == 4'(MAX_CONSEC));
  assign busy      = (state != IDLE);

  arb_pick #(
    .FIXED_PRI(FIXED_PRI != 0)
  ) u_pick (
    .req0     (req0),
    .req1     (req1),
    .last     (last),
    .guard_hit(guard_hit),
    .winner   (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant   = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_cmd == MREAD) begin
          cnt_d   = 2'(READ_LAT - 1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          cap     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= 16'd0;
      p1_rdata  <= 16'd0;
      ram_cmd   <= MNONE;
      ram_addr  <= 9'd0;
      ram_wdata <= 16'd0;
      last      <= 1'b1;
      owner     <= 1'b0;
      consec    <= 4'd0;
    end else begin
      p0_gnt    <= grant && !win;
      p1_gnt    <= grant && win;
      p0_rvalid <= cap && !owner;
      p1_rvalid <= cap && owner;
      if (cap && !owner) p0_rdata <= ram_rdata;
      if (cap && owner)  p1_rdata <= ram_rdata;
      if (grant) begin
        ram_cmd   <= win ? p1_cmd : p0_cmd;
        ram_addr  <= win ? p1_addr : p0_addr;
        ram_wdata <= win ? p1_wdata : p0_wdata;
        last      <= win;
        owner     <= win;
      end else if (state == ISSUE) begin
        ram_cmd <= MNONE;
      end
      // starvation guard: count port 0 wins while port 1 waits
      if (grant && win)
        consec <= 4'd0;
      else if (grant && req1)
        consec <= consec + 4'd1;
      else if (state == IDLE && !req1)
        consec <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (RR lat1, RR lat3, fixed lat1),
// directed vector table plus randomized traffic against a reference model.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int N    = 3;
  localparam int MAXC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  p0_cmd [N], p1_cmd [N], ram_cmd [N];
  logic [8:0]  p0_addr [N], p1_addr [N], ram_addr [N];
  logic [15:0] p0_wdata [N], p1_wdata [N];
  logic [15:0] p0_rdata [N], p1_rdata [N], ram_wdata [N];
  logic        p0_gnt [N], p1_gnt [N];
  logic        p0_rvalid [N], p1_rvalid [N], busy [N];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] init_val(int g, logic [8:0] a);
    if (a == 9'h005) return 16'hBEEF;
    return 16'h5A00 ^ {7'd0, a} ^ 16'(g * 4096);
  endfunction

  function automatic int lat_of(int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic bit fix_of(int g);
    return g == 2;
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int L = (g == 1) ? 3 : 1;
    localparam int F = (g == 2) ? 1 : 0;
    logic [15:0] mem [512];
    logic [15:0] pipe [4];
    logic [15:0] rd;
    assign rd = pipe[L-1];

    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 512; i++) mem[i] <= init_val(g, 9'(i));
      end else if (ram_cmd[g] == MWRITE) begin
        mem[ram_addr[g]] <= ram_wdata[g];
      end
      pipe[0] <= (ram_cmd[g] == MREAD) ? mem[ram_addr[g]] : 16'hDEAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    mem_arbiter #(
      .READ_LAT(L), .FIXED_PRI(F), .MAX_CONSEC(MAXC)
    ) u_dut (
      .clk(clk), .reset(reset),
      .p0_cmd(p0_cmd[g]), .p0_addr(p0_addr[g]),
      .p0_wdata(p0_wdata[g]), .p0_gnt(p0_gnt[g]),
      .p0_rvalid(p0_rvalid[g]), .p0_rdata(p0_rdata[g]),
      .p1_cmd(p1_cmd[g]), .p1_addr(p1_addr[g]),
      .p1_wdata(p1_wdata[g]), .p1_gnt(p1_gnt[g]),
      .p1_rvalid(p1_rvalid[g]), .p1_rdata(p1_rdata[g]),
      .ram_cmd(ram_cmd[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(rd),
      .busy(busy[g])
    );
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(int g, int p);
    return p != 0 ? p1_gnt[g] : p0_gnt[g];
  endfunction

  function automatic logic rv_of(int g, int p);
    return p != 0 ? p1_rvalid[g] : p0_rvalid[g];
  endfunction

  function automatic logic [15:0] rd_of(int g, int p);
    return p != 0 ? p1_rdata[g] : p0_rdata[g];
  endfunction

  task automatic set_req(int g, int p, logic [1:0] c,
                         logic [8:0] a, logic [15:0] d);
    if (p != 0) begin
      p1_cmd[g] = c; p1_addr[g] = a; p1_wdata[g] = d;
    end else begin
      p0_cmd[g] = c; p0_addr[g] = a; p0_wdata[g] = d;
    end
  endtask

  typedef struct {
    int          g;
    int          p;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  task automatic do_txn(vec_t v);
    int d;
    int op;
    op = 1 - v.p;
    set_req(v.g, v.p, v.cmd, v.addr, v.wdata);
    d = 0;
    do begin
      tick();
      d++;
    end while (!gnt_of(v.g, v.p) && d < 8);
    chk("gnt_latency", d, 1);
    if (!gnt_of(v.g, v.p)) begin
      set_req(v.g, v.p, MNONE, 9'd0, 16'd0);
      return;
    end
    chk("gnt_other", gnt_of(v.g, op), 0);
    chk("issue_cmd", ram_cmd[v.g], v.cmd);
    chk("issue_addr", ram_addr[v.g], v.addr);
    chk("issue_busy", busy[v.g], 1);
    if (v.cmd == MWRITE) chk("issue_wdata", ram_wdata[v.g], v.wdata);
    tick();
    set_req(v.g, v.p, MNONE, 9'd0, 16'd0);
    chk("gnt_pulse", gnt_of(v.g, v.p), 0);
    if (v.cmd == MWRITE) begin
      chk("wr_cmd_off", ram_cmd[v.g], MNONE);
      chk("wr_busy_off", busy[v.g], 0);
    end else begin
      d = 1;
      while (!rv_of(v.g, v.p) && d < 12) begin
        tick();
        d++;
      end
      chk("rd_latency", d, lat_of(v.g) + 1);
      chk("rd_data", rd_of(v.g, v.p), v.exp);
      chk("rd_other_rv", rv_of(v.g, op), 0);
      tick();
      chk("rv_pulse", rv_of(v.g, v.p), 0);
    end
  endtask

  // transaction-level reference model state for random traffic
  logic [15:0] ref_mem [N][512];
  logic [1:0]  rq_cmd [2];
  logic [8:0]  rq_addr [2];
  logic [15:0] rq_wd [2];
  bit          renew [2];
  int          exp_due [2];
  logic [15:0] exp_dat [2];
  int          cyc, busy_end, pred, last_m, consec_m;
  int          glog [$];

  task automatic regen(int p, int mode);
    int r;
    rq_cmd[p] = MNONE;
    rq_addr[p] = 9'h100 + 9'($urandom_range(0, 15));
    rq_wd[p] = 16'($urandom);
    if (mode == 1) begin
      rq_cmd[p] = MREAD;
    end else if (mode == 2) begin
      r = $urandom_range(0, 9);
      if (r == 3) rq_cmd[p] = 2'b11;
      else if (r >= 4 && r <= 6) rq_cmd[p] = MREAD;
      else if (r >= 7) rq_cmd[p] = MWRITE;
    end
  endtask

  task automatic start_run(int g);
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq_cmd[p] = MNONE; rq_addr[p] = 9'd0; rq_wd[p] = 16'd0;
      renew[p] = 1'b0; exp_due[p] = -1;
      set_req(g, p, MNONE, 9'd0, 16'd0);
    end
    tick();
    tick();
    reset = 1'b1;
    cyc = 0; busy_end = -1; pred = -1;
    last_m = 1; consec_m = 0;
    glog.delete();
  endtask

  task automatic step(int g, int mode);
    bit ng [2];
    bit r0, r1, free;
    int w;
    tick();
    cyc++;
    chk("gnt0_model", p0_gnt[g], pred == 0);
    chk("gnt1_model", p1_gnt[g], pred == 1);
    for (int p = 0; p < 2; p++) begin
      ng[p] = gnt_of(g, p);
      if (ng[p]) begin
        glog.push_back(p);
        chk("rnd_ram_cmd", ram_cmd[g], rq_cmd[p]);
        chk("rnd_ram_addr", ram_addr[g], rq_addr[p]);
        if (rq_cmd[p] == MWRITE) begin
          chk("rnd_ram_wdata", ram_wdata[g], rq_wd[p]);
          ref_mem[g][rq_addr[p]] = rq_wd[p];
          busy_end = cyc;
        end else begin
          exp_due[p] = cyc + lat_of(g) + 1;
          exp_dat[p] = ref_mem[g][rq_addr[p]];
          busy_end = cyc + lat_of(g);
        end
      end
    end
    chk("rnd_busy", busy[g], cyc <= busy_end);
    for (int p = 0; p < 2; p++) begin
      chk("rnd_rvalid", rv_of(g, p), exp_due[p] == cyc);
      if (exp_due[p] == cyc) begin
        chk("rnd_rdata", rd_of(g, p), exp_dat[p]);
        exp_due[p] = -1;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (renew[p] || (!cmd_valid(rq_cmd[p]) &&
          (mode != 2 || $urandom_range(0, 1) == 0)))
        regen(p, mode);
      renew[p] = ng[p];
      set_req(g, p, rq_cmd[p], rq_addr[p], rq_wd[p]);
    end
    free = cyc > busy_end;
    r0 = cmd_valid(rq_cmd[0]);
    r1 = cmd_valid(rq_cmd[1]);
    if (fix_of(g) && free && !r1) consec_m = 0;
    pred = -1;
    if (free && (r0 || r1)) begin
      if (r0 && !r1) w = 0;
      else if (r1 && !r0) w = 1;
      else if (fix_of(g)) w = (consec_m == MAXC) ? 1 : 0;
      else w = (last_m == 0) ? 1 : 0;
      pred = w;
      last_m = w;
      if (w == 1) consec_m = 0;
      else if (r1) consec_m++;
    end
  endtask

  task automatic run(int g, int n, int mode);
    start_run(g);
    for (int i = 0; i < n; i++) step(g, mode);
    for (int i = 0; i < 24; i++) step(g, 0);
    chk("drain_p0", exp_due[0], -1);
    chk("drain_p1", exp_due[1], -1);
  endtask

  vec_t vt [7];
  int   d;

  initial begin
    for (int g = 0; g < N; g++) begin
      for (int p = 0; p < 2; p++) set_req(g, p, MNONE, 9'd0, 16'd0);
      for (int i = 0; i < 512; i++) ref_mem[g][i] = init_val(g, 9'(i));
    end
    vt[0] = '{0, 0, MREAD,  9'h005, 16'h0000, 16'hBEEF};
    vt[1] = '{0, 1, MWRITE, 9'h1FF, 16'h1234, 16'h0000};
    vt[2] = '{0, 0, MREAD,  9'h1FF, 16'h0000, 16'h1234};
    vt[3] = '{1, 0, MREAD,  9'h005, 16'h0000, 16'hBEEF};
    vt[4] = '{1, 1, MWRITE, 9'h0A0, 16'hCAFE, 16'h0000};
    vt[5] = '{1, 1, MREAD,  9'h0A0, 16'h0000, 16'hCAFE};
    vt[6] = '{2, 1, MREAD,  9'h003, 16'h0000, init_val(2, 9'h003)};

    tick();
    tick();
    preload = 1'b0;
    for (int g = 0; g < N; g++) begin
      chk("rst_ctl", {p0_gnt[g], p1_gnt[g], p0_rvalid[g],
                      p1_rvalid[g], busy[g], ram_cmd[g]}, 0);
      chk("rst_ram", {ram_addr[g], ram_wdata[g]}, 0);
      chk("rst_rdata", {p0_rdata[g], p1_rdata[g]}, 0);
    end
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_txn(vt[i]);
      if (i == 0) chk("p1_quiet", {p1_gnt[0], p1_rvalid[0], p1_rdata[0]}, 0);
    end

    p0_cmd[0] = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cmd11_ignored", {p0_gnt[0], p1_gnt[0], busy[0]}, 0);
    end
    p0_cmd[0] = MNONE;
    tick();

    set_req(1, 0, MREAD, 9'h005, 16'd0);
    d = 0;
    do begin
      tick();
      d++;
    end while (!p0_gnt[1] && d < 8);
    chk("wait_rst_gnt", d, 1);
    tick();
    set_req(1, 0, MNONE, 9'd0, 16'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("wait_rst_ctl", {p0_gnt[1], p0_rvalid[1], busy[1], ram_cmd[1]}, 0);
    chk("wait_rst_rdata", p0_rdata[1], 0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_rv_after_rst", {p0_rvalid[1], p1_rvalid[1]}, 0);
    end
    do_txn('{1, 0, MREAD, 9'h0A0, 16'h0000, 16'hCAFE});

    run(0, 40, 1);
    for (int i = 0; i < 6; i++)
      chk("rr_pattern", i < glog.size() ? glog[i] : 9, i % 2);

    run(2, 60, 1);
    for (int i = 0; i < 10; i++)
      chk("fixed_pattern", i < glog.size() ? glog[i] : 9,
          (i % 5 == 4) ? 1 : 0);

    run(0, 400, 2);
    run(1, 400, 2);
    run(2, 400, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single 512x16 synchronous RAM shared by the CPU and a program loader/DMA port.
- Port 0 connects to the cpu mem_cmd/mem_addr/out bus. Port 1 connects to the loader.
- The block chooses one requester, drives the registered RAM command, waits out the RAM read latency and returns the read data with a one-cycle valid pulse.
- It replaces the direct CPU-to-RAM wiring at the top level.

Parameters:
- READ_LAT, 1, RAM read latency in cycles (legal 1..4).
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 has fixed priority with a starvation guard.
- MAX_CONSEC, 4, in fixed-priority mode, the maximum number of consecutive port 0 grants while port 1 is waiting (legal 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- p0_cmd  in  2  port 0 command: MNONE=00, MREAD=01, MWRITE=10; 11 is ignored.
- p0_addr  in  9  port 0 word address.
- p0_wdata  in  16  port 0 write data.
- p0_gnt  out  1  one-cycle pulse: port 0 request accepted.
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid.
- p0_rdata  out  16  port 0 read data; held until the next port 0 read completes.
- p1_cmd, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_cmd  out  2  registered RAM command.
- ram_addr  out  9  registered RAM address.
- ram_wdata  out  16  registered RAM write data.
- ram_rdata  in  16  RAM read data, valid READ_LAT cycles after the cycle ram_cmd=MREAD is presented.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - state goes to IDLE.
  - ram_cmd=MNONE, ram_addr=0, ram_wdata=0.
  - All gnt and rvalid outputs = 0; p0_rdata = p1_rdata = 0.
  - last=1, so port 0 wins the first contention.
  - consec=0.
  - An in-flight read is discarded; no rvalid is issued after reset releases.
- Requester rule:
  - Hold cmd/addr/wdata stable until gnt is sampled high.
  - Drop cmd, or present the next request, in the cycle after gnt.
  - A request still present after gnt is treated as a new request.
- States:
  - IDLE:
    - If no valid request, stay in IDLE.
    - If one or both ports request, pick the winner (rules below) and latch its cmd/addr/wdata into the ram_* registers.
    - Set gnt_winner=1 for the next cycle, update last, go to ISSUE.
  - ISSUE:
    - ram_cmd is visible this cycle. Requests are ignored.
    - On MWRITE, the RAM writes at the end of this cycle; go to IDLE.
    - On MREAD, load wait counter = READ_LAT-1 and go to WAIT.
    - ram_cmd returns to MNONE on leaving ISSUE.
  - WAIT:
    - While counter > 0, decrement.
    - When counter = 0, capture ram_rdata into rdata_owner, pulse rvalid_owner for 1 cycle, go to IDLE.
    - With READ_LAT=1, WAIT lasts exactly one cycle.
- Latency:
  - Write: request seen in IDLE to gnt = 1 cycle; RAM write occurs in the same cycle gnt is high.
  - Read: rvalid asserts READ_LAT+1 cycles after gnt.
  - Back-to-back throughput: write every 2 cycles; read every READ_LAT+2 cycles.
- Arbitration, round-robin (FIXED_PRI=0):
  - A single requester wins.
  - On simultaneous requests, the port not in last wins.
- Arbitration, fixed priority (FIXED_PRI=1):
  - Port 0 wins contention unless consec = MAX_CONSEC; then port 1 wins.
  - consec increments on each port 0 grant made while p1_cmd is valid.
  - consec resets to 0 on any port 1 grant, and on any cycle in IDLE where port 1 is not requesting.
- Boundary cases:
  - cmd=11 is never granted and never changes state.
  - gnt is never asserted to both ports in the same cycle.
  - rvalid is never asserted without a preceding read gnt to the same port.
  - The address has no wrap logic; it passes through 9 bits unchanged.

Decomposition:
- Shared package mem_pkg holds:
  - Constants MNONE/MREAD/MWRITE (2-bit).
  - Arbiter state encoding: IDLE, ISSUE, WAIT (2-bit).
- One combinational sub-module, arb_pick:
  - Inputs: req0, req1, last, FIXED_PRI, guard_hit.
  - Output: winner.
  - Contains no state.

Test Plan:
- Reset, then a single port 0 MREAD at addr 9'h005 with the RAM holding 16'hBEEF (READ_LAT=1) -> p0_gnt pulses 1 cycle; ram_cmd=01, ram_addr=005 the cycle after; p0_rvalid pulses with p0_rdata=BEEF 2 cycles after gnt; p1 outputs stay 0.
- Port 1 MWRITE addr 9'h1FF, data 16'h1234 -> ram_cmd=10 for exactly 1 cycle; busy high 1 cycle; a following port 0 read of 1FF returns 1234.
- Both ports issue back-to-back reads continuously, FIXED_PRI=0 -> grants alternate 0,1,0,1; never both ports granted in one cycle.
- FIXED_PRI=1, MAX_CONSEC=4, both ports continuously requesting -> grant pattern 0,0,0,0,1 repeating.
- READ_LAT=3, port 0 read -> p0_rvalid exactly 4 cycles after gnt; the data matches the RAM model.
- reset asserted while in WAIT -> all outputs 0 immediately; no rvalid after release; a new request is serviced normally.
- p0_cmd=11 held for 10 cycles -> no gnt; state stays IDLE.
